testport_write_capture: RTL and testbench

- Sits directly upstream of the test-bench result checker, snooping the CPU-side data-memory write bus (word address, write data, write enable).
- Turns raw bus activity into a clean stream of result words.
- Filters writes to the test port and collapses D-cache-stall-extended writes into single events.
- Converts little-endian bus data to readable order and buffers results in a small FIFO with a valid/ready interface toward the checker.

---
 rtl/tpc_pkg.sv | 25 ++
 rtl/tpc_fifo.sv | 65 ++++++
 rtl/testport_write_capture.sv | 149 ++++++++++++++
 tb/tb_testport_write_capture.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpc_pkg.sv
// -----------------------------------------------------------------------------
// tpc_pkg
// Shared definitions for the test-port write capture block:
//   - capture FSM state encoding
//   - default test-port address and session delimiter symbols
//   - little-endian bus to readable-order byte swap
// -----------------------------------------------------------------------------
package tpc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    DONE    = 2'b10
  } tpc_state_e;

  localparam logic [29:0] TPC_TEST_PORT    = 30'h10;
  localparam logic [31:0] TPC_BEGIN_SYMBOL = 32'h0000_0168;
  localparam logic [31:0] TPC_END_SYMBOL   = 32'hFFFF_FD5D;

  // The CPU stores words little-endian; the checker compares readable order.
  function automatic logic [31:0] tpc_bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/tpc_fifo.sv
// -----------------------------------------------------------------------------
// tpc_fifo
// Generic synchronous FIFO, no bypass: a pushed word appears at the head one
// cycle after the push. A push while full is accepted only if a pop happens in
// the same cycle. Synchronous active-low reset empties the FIFO.
//
// Ports:
//   clk      in   clock
//   rst_ni   in   synchronous active-low reset
//   push_i   in   write data_i this cycle
//   data_i   in   WIDTH-bit write data
//   pop_i    in   remove head this cycle (ignored when empty)
//   data_o   out  head word (undefined content when empty)
//   full_o   out  DEPTH words stored
//   empty_o  out  no words stored
// -----------------------------------------------------------------------------
module tpc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: storage is deliberately not reset; emptiness is tracked by the
  // pointers alone, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  assign data_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/testport_write_capture.sv
// -----------------------------------------------------------------------------
// testport_write_capture
// Snoops the CPU data-memory write bus and turns writes to the test port into a
// clean stream of readable-order result words for the bench checker. A session
// opens on BEGIN_SYMBOL (not forwarded) and closes after END_SYMBOL is queued.
// A write held across a D-cache stall counts once (rising edge of wen).
//
// Optional feature (macro TPC_TIMEOUT_EN): idle watchdog that ends a capture
// session after TIMEOUT cycles without a write event and sets a sticky flag.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-low reset
//   addr        in   [29:0] bus word address
//   data        in   [31:0] bus write data, little-endian
//   wen         in   bus write enable (may be held during stalls)
//   out_valid   out  FIFO head holds a word
//   out_data    out  [31:0] head word, readable order, 0 when empty
//   out_last    out  head word is END_SYMBOL
//   out_ready   in   checker consumes the head this cycle
//   busy        out  capture session active
//   done        out  session finished (left only by reset)
//   overflow    out  sticky: a word was dropped on a full FIFO
//   timeout     out  sticky watchdog flag (0 without TPC_TIMEOUT_EN)
//   word_count  out  [7:0] words queued this session, saturating at 255
// -----------------------------------------------------------------------------
module testport_write_capture
  import tpc_pkg::*;
#(
  parameter logic [29:0] TEST_PORT    = TPC_TEST_PORT,
  parameter logic [31:0] BEGIN_SYMBOL = TPC_BEGIN_SYMBOL,
  parameter logic [31:0] END_SYMBOL   = TPC_END_SYMBOL,
  parameter int          DEPTH        = 4
`ifdef TPC_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT      = 16'd4096
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] addr,
  input  logic [31:0] data,
  input  logic        wen,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        timeout,
  output logic [7:0]  word_count
);

  tpc_state_e  state_q;
  logic        wen_q;
  logic        overflow_q;
  logic [7:0]  word_count_q;

  logic [31:0] swapped;
  logic        wr_event;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_head;
  logic        pop;
  logic        push_req;
  logic        push_ok;
  logic        drop;
  logic        timeout_hit;

  assign swapped  = tpc_bswap(data);
  assign wr_event = wen && !wen_q && (addr == TEST_PORT);

  assign pop      = !fifo_empty && out_ready;
  assign push_req = (state_q == CAPTURE) && wr_event;
  // A full FIFO still accepts the word if the checker frees a slot this cycle.
  assign push_ok  = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  tpc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (rst),
    .push_i  (push_ok),
    .data_i  (swapped),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef TPC_TIMEOUT_EN
  logic [15:0] idle_cnt_q;
  logic        timeout_q;

  assign timeout_hit = (state_q == CAPTURE) && !wr_event && (idle_cnt_q == TIMEOUT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (state_q != CAPTURE || wr_event) begin
      idle_cnt_q <= '0;
    end else if (timeout_hit) begin
      timeout_q  <= 1'b1;
    end else begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking would make results depend on order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      wen_q        <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      wen_q <= wen;
      if (drop) overflow_q <= 1'b1;
      if (push_ok && word_count_q != 8'hFF) word_count_q <= word_count_q + 8'd1;
      case (state_q)
        IDLE:    if (wr_event && swapped == BEGIN_SYMBOL) state_q <= CAPTURE;
        // A dropped END_SYMBOL does not close the session.
        CAPTURE: if ((push_ok && swapped == END_SYMBOL) || timeout_hit) state_q <= DONE;
        DONE:    state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? 32'h0 : fifo_head;
  assign out_last   = !fifo_empty && (fifo_head == END_SYMBOL);
  assign busy       = (state_q == CAPTURE);
  assign done       = (state_q == DONE);
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_testport_write_capture.sv
// -----------------------------------------------------------------------------
// tb_testport_write_capture
// Self-checking bench: a queue-based reference model of the capture rules is
// compared against the DUT on every falling edge, with directed scenarios
// pinned by literal expectations followed by randomized bus traffic.
// -----------------------------------------------------------------------------
module tb_testport_write_capture;

  localparam logic [29:0] TP      = 30'h10;
  localparam logic [31:0] BEG_SYM = 32'h0000_0168;
  localparam logic [31:0] END_SYM = 32'hFFFF_FD5D;
  localparam logic [31:0] BEG_BUS = 32'h6801_0000;
  localparam logic [31:0] END_BUS = 32'h5DFD_FFFF;
  localparam int          DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        timeout;
  logic [7:0]  word_count;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  testport_write_capture #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .data       (data),
    .wen        (wen),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .timeout    (timeout),
    .word_count (word_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bus(input logic [31:0] readable);
    return {readable[7:0], readable[15:8], readable[23:16], readable[31:24]};
  endfunction

  // ---------------- reference model ----------------
  int          m_state;     // 0 idle, 1 capture, 2 done
  bit          m_wen_prev;
  logic [31:0] m_q [$];
  bit          m_ovf;
  int          m_wc;

  always @(posedge clk) begin : model
    logic [31:0] sw;
    bit evt, do_pop, was_full;
    if (!rst) begin
      m_state = 0; m_wen_prev = 0; m_ovf = 0; m_wc = 0;
      m_q.delete();
    end else begin
      sw       = {data[7:0], data[15:8], data[23:16], data[31:24]};
      evt      = wen && !m_wen_prev && (addr == TP);
      was_full = (m_q.size() == DEPTH);
      do_pop   = (m_q.size() > 0) && out_ready;
      if (do_pop) void'(m_q.pop_front());
      if (m_state == 1 && evt) begin
        if (!was_full || do_pop) begin
          m_q.push_back(sw);
          if (m_wc < 255) m_wc++;
          if (sw == END_SYM) m_state = 2;
        end else begin
          m_ovf = 1;
        end
      end else if (m_state == 0 && evt && sw == BEG_SYM) begin
        m_state = 1;
      end
      m_wen_prev = wen;
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] exp_data;
    if (chk_en) begin
      exp_data = (m_q.size() > 0) ? m_q[0] : 32'h0;
      check("cmp_out_valid",  32'(out_valid),  32'(m_q.size() > 0));
      check("cmp_out_data",   out_data,        exp_data);
      check("cmp_out_last",   32'(out_last),   32'((m_q.size() > 0) && exp_data == END_SYM));
      check("cmp_busy",       32'(busy),       32'(m_state == 1));
      check("cmp_done",       32'(done),       32'(m_state == 2));
      check("cmp_overflow",   32'(overflow),   32'(m_ovf));
      check("cmp_timeout",    32'(timeout),    32'h0);
      check("cmp_word_count", 32'(word_count), 32'(m_wc));
    end
  end

  // ---------------- stimulus ----------------
  // Apply inputs at a falling edge and return at the next falling edge,
  // after the DUT has consumed them.
  task automatic drive(input logic [29:0] a, input logic [31:0] d,
                       input logic w, input logic r, input logic rs);
    addr = a; data = d; wen = w; out_ready = r; rst = rs;
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    drive(30'h0, 32'h0, 1'b0, r, 1'b1);
  endtask

  task automatic ev(input logic [29:0] a, input logic [31:0] d, input logic r);
    drive(a, d, 1'b1, r, 1'b1);
    idle(r);
  endtask

  initial begin
    rst = 1'b0; addr = '0; data = '0; wen = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    // Reset state
    drive(30'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst_out_valid",  32'(out_valid),  32'h0);
    check("rst_word_count", 32'(word_count), 32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    check("rst_done",       32'(done),       32'h0);
    check("rst_overflow",   32'(overflow),   32'h0);

    // Address filter
    ev(30'h11, BEG_BUS, 1'b0);
    check("filt_busy",      32'(busy),       32'h0);
    check("filt_out_valid", 32'(out_valid),  32'h0);

    // Begin and first capture
    ev(TP, BEG_BUS, 1'b0);
    check("begin_busy",      32'(busy),       32'h1);
    check("begin_out_valid", 32'(out_valid),  32'h0);
    drive(TP, 32'hFFFF_0000, 1'b1, 1'b0, 1'b1);
    check("first_out_valid", 32'(out_valid),  32'h1);
    check("first_out_data",  out_data,        32'h0000_FFFF);
    check("first_count",     32'(word_count), 32'h1);
    idle(1'b0);

    // Held write counts once
    for (int i = 0; i < 5; i++) drive(TP, 32'h0100_0000, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    check("held_count", 32'(word_count), 32'h2);
    idle(1'b1);
    check("held_head",  out_data,        32'h0000_0001);
    idle(1'b1);
    check("held_empty", 32'(out_valid),  32'h0);

    // Overflow on a full FIFO, then drain
    for (int i = 1; i <= 5; i++) ev(TP, to_bus(32'(i)), 1'b0);
    check("ovf_flag",  32'(overflow),   32'h1);
    check("ovf_count", 32'(word_count), 32'h6);
    check("ovf_head1", out_data,        32'h1);
    for (int j = 2; j <= 4; j++) begin
      idle(1'b1);
      check("ovf_drain", out_data, 32'(j));
    end
    idle(1'b1);
    check("ovf_empty", 32'(out_valid), 32'h0);

    // End of session
    drive(TP, END_BUS, 1'b1, 1'b0, 1'b1);
    check("end_data",  out_data,        END_SYM);
    check("end_last",  32'(out_last),   32'h1);
    check("end_done",  32'(done),       32'h1);
    check("end_count", 32'(word_count), 32'h7);
    idle(1'b0);
    ev(TP, to_bus(32'h9), 1'b0);
    check("post_end_count", 32'(word_count), 32'h7);
    check("post_end_head",  out_data,        END_SYM);

    // Reset mid-session
    drive(30'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    ev(TP, BEG_BUS, 1'b0);
    ev(TP, to_bus(32'hA), 1'b0);
    ev(TP, to_bus(32'hB), 1'b0);
    check("mid_busy",  32'(busy),       32'h1);
    check("mid_count", 32'(word_count), 32'h2);
    drive(30'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("mid_rst_valid", 32'(out_valid),  32'h0);
    check("mid_rst_data",  out_data,        32'h0);
    check("mid_rst_busy",  32'(busy),       32'h0);
    check("mid_rst_count", 32'(word_count), 32'h0);
    check("mid_rst_ovf",   32'(overflow),   32'h0);
    ev(TP, BEG_BUS, 1'b0);
    check("restart_busy",  32'(busy),       32'h1);
    check("restart_count", 32'(word_count), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic [29:0] a;
      logic [31:0] d;
      int ra, rd;
      ra = $urandom_range(0, 9);
      rd = $urandom_range(0, 19);
      a  = (ra < 7) ? TP : (ra == 7) ? 30'h11 : 30'($urandom);
      d  = (rd < 4) ? BEG_BUS : (rd == 4) ? END_BUS : $urandom;
      drive(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 149) != 0));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
